// File: rtl/reorder_logic_pkg.sv
// Shared constants, width helpers and FSM encoding for the re-order logic
// (trace dispatcher and re-order control).
package reorder_logic_pkg;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Bit width needed to index n entries, never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (clog2(n) == 0) ? 1 : clog2(n);
    endfunction

    localparam int unsigned NUM_QUEUES_DEF = 4;
    localparam int unsigned DEPTH_DEF      = 64;
    localparam int unsigned MAX_SEGS_DEF   = 16;

    localparam int unsigned SEL_WIDTH_DEF = width_of(NUM_QUEUES_DEF);
    localparam int unsigned ID_WIDTH_DEF  = width_of(DEPTH_DEF);
    localparam int unsigned CNT_WIDTH_DEF = clog2(MAX_SEGS_DEF) + 1;

    localparam logic BREAKPOINT_DEF = 1'b1;

    typedef enum logic {
        StIdle   = 1'b0,
        StActive = 1'b1
    } state_e;

endpackage

// File: rtl/reorder_trace_dispatcher_if.sv
// Request/queue/trace bundle of the trace dispatcher. The slave side is the
// dispatcher; the master side is whatever surrounds it (source, queues, re-order control).
interface reorder_trace_dispatcher_if
    import reorder_logic_pkg::*;
#(
    parameter int unsigned NUM_QUEUES = NUM_QUEUES_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF
);
    localparam int unsigned SEL_WIDTH = width_of(NUM_QUEUES);
    localparam int unsigned ID_WIDTH  = width_of(DEPTH);

    logic                  txn_valid_i;
    logic                  txn_ready_o;
    logic [ID_WIDTH-1:0]   txn_id_i;
    logic                  seg_valid_i;
    logic                  seg_ready_o;
    logic [SEL_WIDTH-1:0]  seg_sel_i;
    logic                  seg_last_i;
    logic                  seg_abort_i;
    logic                  full_i;
    logic [NUM_QUEUES-1:0] queue_full_i;
    logic [NUM_QUEUES-1:0] queue_push_o;
    logic                  trace_id_push_o;
    logic [ID_WIDTH-1:0]   trace_id_value_o;
    logic                  trace_push_o;
    logic [SEL_WIDTH-1:0]  trace_sel_o;
    logic                  trace_break_o;
    logic                  trace_update_o;
    logic                  busy_o;

    modport master (
        output txn_valid_i, txn_id_i, seg_valid_i, seg_sel_i, seg_last_i, seg_abort_i,
               full_i, queue_full_i,
        input  txn_ready_o, seg_ready_o, queue_push_o, trace_id_push_o, trace_id_value_o,
               trace_push_o, trace_sel_o, trace_break_o, trace_update_o, busy_o
    );

    modport slave (
        input  txn_valid_i, txn_id_i, seg_valid_i, seg_sel_i, seg_last_i, seg_abort_i,
               full_i, queue_full_i,
        output txn_ready_o, seg_ready_o, queue_push_o, trace_id_push_o, trace_id_value_o,
               trace_push_o, trace_sel_o, trace_break_o, trace_update_o, busy_o
    );

endinterface

// File: rtl/reorder_trace_dispatcher.sv
// Producer-side trace dispatcher: forwards each transaction segment to its
// processing queue and emits the trace stream (ID, selector, breakpoint, update)
// used by the re-order control to rebuild completion order.
module reorder_trace_dispatcher
    import reorder_logic_pkg::*;
#(
    parameter int unsigned NUM_QUEUES = NUM_QUEUES_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned MAX_SEGS   = MAX_SEGS_DEF,
    parameter logic        BREAKPOINT = BREAKPOINT_DEF
) (
    input logic                        clk_i,
    input logic                        arst_i,
    reorder_trace_dispatcher_if.slave  bus
);

    localparam int unsigned SEL_WIDTH = width_of(NUM_QUEUES);
    localparam int unsigned ID_WIDTH  = width_of(DEPTH);
    localparam int unsigned CNT_WIDTH = clog2(MAX_SEGS) + 1;
    // Full selector range, so out-of-range selectors decode to nothing.
    localparam int unsigned SEL_SPAN  = 1 << SEL_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_SEGS - 1);

    function automatic logic [NUM_QUEUES-1:0] sel_to_onehot(input logic [SEL_WIDTH-1:0] sel);
        logic [SEL_SPAN-1:0] wide;
        wide      = '0;
        wide[sel] = 1'b1;
        return NUM_QUEUES'(wide);
    endfunction

    state_e                 state_q;
    logic [ID_WIDTH-1:0]    id_q;
    logic [CNT_WIDTH-1:0]   seg_cnt_q;

    logic [NUM_QUEUES-1:0]  queue_push_q;
    logic                   trace_id_push_q;
    logic [ID_WIDTH-1:0]    trace_id_value_q;
    logic                   trace_push_q;
    logic [SEL_WIDTH-1:0]   trace_sel_q;
    logic                   trace_break_q;
    logic                   trace_update_q;

    logic [SEL_SPAN-1:0]    queue_full_ext;
    logic                   sel_queue_full;
    logic                   seg_ready;
    logic                   seg_accept;
    logic                   seg_break;

    // Segment handshake and breakpoint decision for the current cycle.
    always_comb begin
        queue_full_ext = SEL_SPAN'(bus.queue_full_i);
        sel_queue_full = queue_full_ext[bus.seg_sel_i];
        seg_ready      = (state_q == StActive) & ~bus.full_i & ~sel_queue_full;
        seg_accept     = bus.seg_valid_i & seg_ready;
        seg_break      = bus.seg_last_i | bus.seg_abort_i | (seg_cnt_q == LAST_CNT);
    end

    // Transaction FSM with registered queue/trace outputs; pulses last one cycle.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q          <= StIdle;
            id_q             <= '0;
            seg_cnt_q        <= '0;
            queue_push_q     <= '0;
            trace_id_push_q  <= 1'b0;
            trace_id_value_q <= '0;
            trace_push_q     <= 1'b0;
            trace_sel_q      <= '0;
            trace_break_q    <= 1'b0;
            trace_update_q   <= 1'b0;
        end else begin
            queue_push_q    <= '0;
            trace_id_push_q <= 1'b0;
            trace_push_q    <= 1'b0;
            trace_update_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.txn_valid_i) begin
                        id_q      <= bus.txn_id_i;
                        seg_cnt_q <= '0;
                        state_q   <= StActive;
                    end
                end
                StActive: begin
                    if (seg_accept) begin
                        queue_push_q  <= sel_to_onehot(bus.seg_sel_i);
                        trace_push_q  <= 1'b1;
                        trace_sel_q   <= bus.seg_sel_i;
                        trace_break_q <= seg_break ? BREAKPOINT : ~BREAKPOINT;
                        // The ID travels with the first segment only.
                        if (seg_cnt_q == '0) begin
                            trace_id_push_q  <= 1'b1;
                            trace_id_value_q <= id_q;
                        end
                        if (seg_break) begin
                            state_q <= StIdle;
                        end else begin
                            seg_cnt_q <= seg_cnt_q + CNT_WIDTH'(1);
                        end
                    end else if (bus.seg_abort_i) begin
                        // Nothing traced yet means nothing to close off.
                        trace_update_q <= (seg_cnt_q != '0);
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.txn_ready_o      = (state_q == StIdle);
    assign bus.seg_ready_o      = seg_ready;
    assign bus.busy_o           = (state_q == StActive);
    assign bus.queue_push_o     = queue_push_q;
    assign bus.trace_id_push_o  = trace_id_push_q;
    assign bus.trace_id_value_o = trace_id_value_q;
    assign bus.trace_push_o     = trace_push_q;
    assign bus.trace_sel_o      = trace_sel_q;
    assign bus.trace_break_o    = trace_break_q;
    assign bus.trace_update_o   = trace_update_q;

endmodule

// File: tb/tb_reorder_trace_dispatcher.sv
// Directed bench for the trace dispatcher, built with MAX_SEGS=4 so the
// forced-break boundary is reachable in a few cycles.
module tb_reorder_trace_dispatcher;

    logic clk_i = 1'b0;
    logic arst_i;
    int   total = 0;
    int   bad   = 0;

    reorder_trace_dispatcher_if #(.NUM_QUEUES(4), .DEPTH(64)) bus ();

    reorder_trace_dispatcher #(
        .NUM_QUEUES (4),
        .DEPTH      (64),
        .MAX_SEGS   (4),
        .BREAKPOINT (1'b1)
    ) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic exp_push(input string tag, input logic [1:0] sel, input logic brk,
                            input logic idp, input logic [5:0] idv, input logic [3:0] qp);
        chk({tag, ".push"}, 32'(bus.trace_push_o), 32'd1);
        chk({tag, ".sel"}, 32'(bus.trace_sel_o), 32'(sel));
        chk({tag, ".break"}, 32'(bus.trace_break_o), 32'(brk));
        chk({tag, ".idpush"}, 32'(bus.trace_id_push_o), 32'(idp));
        if (idp) chk({tag, ".idval"}, 32'(bus.trace_id_value_o), 32'(idv));
        chk({tag, ".qpush"}, 32'(bus.queue_push_o), 32'(qp));
        chk({tag, ".update"}, 32'(bus.trace_update_o), 32'd0);
    endtask

    task automatic exp_quiet(input string tag);
        chk({tag, ".push"}, 32'(bus.trace_push_o), 32'd0);
        chk({tag, ".qpush"}, 32'(bus.queue_push_o), 32'd0);
        chk({tag, ".idpush"}, 32'(bus.trace_id_push_o), 32'd0);
    endtask

    task automatic header(input logic [5:0] id);
        bus.txn_valid_i = 1'b1;
        bus.txn_id_i    = id;
        #1;
        chk("hdr.ready", 32'(bus.txn_ready_o), 32'd1);
        tick();
        bus.txn_valid_i = 1'b0;
        chk("hdr.busy", 32'(bus.busy_o), 32'd1);
        chk("hdr.txnready", 32'(bus.txn_ready_o), 32'd0);
    endtask

    task automatic seg(input logic [1:0] sel, input logic last, input logic abort);
        bus.seg_valid_i = 1'b1;
        bus.seg_sel_i   = sel;
        bus.seg_last_i  = last;
        bus.seg_abort_i = abort;
    endtask

    task automatic seg_idle();
        bus.seg_valid_i = 1'b0;
        bus.seg_last_i  = 1'b0;
        bus.seg_abort_i = 1'b0;
    endtask

    initial begin
        arst_i           = 1'b1;
        bus.txn_valid_i  = 1'b0;
        bus.txn_id_i     = '0;
        bus.seg_valid_i  = 1'b0;
        bus.seg_sel_i    = '0;
        bus.seg_last_i   = 1'b0;
        bus.seg_abort_i  = 1'b0;
        bus.full_i       = 1'b0;
        bus.queue_full_i = '0;
        #3;
        exp_quiet("rst");
        chk("rst.update", 32'(bus.trace_update_o), 32'd0);
        chk("rst.busy", 32'(bus.busy_o), 32'd0);
        chk("rst.txnready", 32'(bus.txn_ready_o), 32'd1);
        chk("rst.segready", 32'(bus.seg_ready_o), 32'd0);
        chk("rst.idval", 32'(bus.trace_id_value_o), 32'd0);
        tick();
        tick();
        arst_i = 1'b0;

        // Basic transaction: id 5, selectors 2,0,3.
        header(6'd5);
        seg(2'd2, 1'b0, 1'b0);
        #1;
        chk("basic.segready", 32'(bus.seg_ready_o), 32'd1);
        tick();
        exp_push("basic0", 2'd2, 1'b0, 1'b1, 6'd5, 4'b0100);
        seg(2'd0, 1'b0, 1'b0);
        tick();
        exp_push("basic1", 2'd0, 1'b0, 1'b0, 6'd0, 4'b0001);
        seg(2'd3, 1'b1, 1'b0);
        tick();
        exp_push("basic2", 2'd3, 1'b1, 1'b0, 6'd0, 4'b1000);
        seg_idle();
        chk("basic.busy", 32'(bus.busy_o), 32'd0);
        tick();
        exp_quiet("basic.after");

        // full_i stall for three cycles mid-stream.
        header(6'd7);
        seg(2'd1, 1'b0, 1'b0);
        tick();
        exp_push("stall0", 2'd1, 1'b0, 1'b1, 6'd7, 4'b0010);
        bus.full_i = 1'b1;
        seg(2'd2, 1'b0, 1'b0);
        #1;
        chk("stall.segready", 32'(bus.seg_ready_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_quiet("stall.hold");
        end
        bus.full_i = 1'b0;
        tick();
        exp_push("stall1", 2'd2, 1'b0, 1'b0, 6'd0, 4'b0100);
        seg(2'd3, 1'b1, 1'b0);
        tick();
        exp_push("stall2", 2'd3, 1'b1, 1'b0, 6'd0, 4'b1000);
        seg_idle();
        tick();
        exp_quiet("stall.after");

        // Per-queue stall, then redirect; finish with an accepted abort segment.
        header(6'd3);
        bus.queue_full_i = 4'b0010;
        seg(2'd1, 1'b0, 1'b0);
        #1;
        chk("qfull.blocked", 32'(bus.seg_ready_o), 32'd0);
        bus.seg_sel_i = 2'd0;
        #1;
        chk("qfull.redirect", 32'(bus.seg_ready_o), 32'd1);
        tick();
        exp_push("qfull0", 2'd0, 1'b0, 1'b1, 6'd3, 4'b0001);
        seg(2'd0, 1'b0, 1'b1);
        tick();
        exp_push("abortseg", 2'd0, 1'b1, 1'b0, 6'd0, 4'b0001);
        chk("abortseg.busy", 32'(bus.busy_o), 32'd0);
        seg_idle();
        bus.queue_full_i = '0;
        tick();
        chk("abortseg.update", 32'(bus.trace_update_o), 32'd0);

        // Abort after two segments with no segment valid.
        header(6'd10);
        seg(2'd1, 1'b0, 1'b0);
        tick();
        exp_push("abort2.0", 2'd1, 1'b0, 1'b1, 6'd10, 4'b0010);
        seg(2'd2, 1'b0, 1'b0);
        tick();
        exp_push("abort2.1", 2'd2, 1'b0, 1'b0, 6'd0, 4'b0100);
        seg_idle();
        bus.seg_abort_i = 1'b1;
        tick();
        bus.seg_abort_i = 1'b0;
        chk("abort2.update", 32'(bus.trace_update_o), 32'd1);
        exp_quiet("abort2.nopush");
        chk("abort2.busy", 32'(bus.busy_o), 32'd0);
        tick();
        chk("abort2.updpulse", 32'(bus.trace_update_o), 32'd0);

        // Abort before any segment: silently dropped.
        header(6'd11);
        bus.seg_abort_i = 1'b1;
        tick();
        bus.seg_abort_i = 1'b0;
        exp_quiet("abort0");
        chk("abort0.update", 32'(bus.trace_update_o), 32'd0);
        chk("abort0.busy", 32'(bus.busy_o), 32'd0);

        // MAX_SEGS boundary: 4th segment forces break, 5th stalls until new header.
        header(6'd12);
        for (int i = 0; i < 4; i++) begin
            seg(2'(i), 1'b0, 1'b0);
            tick();
            exp_push("max", 2'(i), (i == 3), (i == 0), 6'd12, 4'(1 << i));
        end
        chk("max.busy", 32'(bus.busy_o), 32'd0);
        seg(2'd0, 1'b0, 1'b0);
        #1;
        chk("max.stall", 32'(bus.seg_ready_o), 32'd0);
        tick();
        exp_quiet("max.held");
        bus.txn_valid_i = 1'b1;
        bus.txn_id_i    = 6'd9;
        tick();
        bus.txn_valid_i = 1'b0;
        exp_quiet("max.hdr");
        #1;
        chk("max.resume", 32'(bus.seg_ready_o), 32'd1);
        tick();
        exp_push("max.new", 2'd0, 1'b0, 1'b1, 6'd9, 4'b0001);
        seg(2'd2, 1'b1, 1'b0);
        tick();
        exp_push("max.end", 2'd2, 1'b1, 1'b0, 6'd0, 4'b0100);
        seg_idle();
        tick();

        // Asynchronous reset mid-transaction.
        header(6'd20);
        seg(2'd1, 1'b0, 1'b0);
        tick();
        seg(2'd2, 1'b0, 1'b0);
        tick();
        exp_push("arst.pre", 2'd2, 1'b0, 1'b0, 6'd0, 4'b0100);
        #2;
        arst_i = 1'b1;
        #1;
        exp_quiet("arst");
        chk("arst.sel", 32'(bus.trace_sel_o), 32'd0);
        chk("arst.idval", 32'(bus.trace_id_value_o), 32'd0);
        chk("arst.busy", 32'(bus.busy_o), 32'd0);
        seg_idle();
        tick();
        arst_i = 1'b0;
        #1;
        chk("arst.txnready", 32'(bus.txn_ready_o), 32'd1);
        tick();
        chk("arst.update", 32'(bus.trace_update_o), 32'd0);
        exp_quiet("arst.after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reorder_trace_dispatcher.md
Name: reorder_trace_dispatcher

Overview:
- Producer-side companion of the re-order logic. Accepts transactions (one ID plus a stream of segments, each targeting one processing queue) and forwards each segment to its queue.
- Emits the matching trace stream (ID push, queue selector, breakpoint flag, end-of-trace update) that the re-order control consumes to rebuild completion order.
- Sits between the request source and the re-order control / processing queues.

Parameters:
- NUM_QUEUES, 4, number of processing queues; SEL_WIDTH = clog2(NUM_QUEUES).
- DEPTH, 64, ID space size; ID_WIDTH = clog2(DEPTH).
- MAX_SEGS, 16, maximum segments per transaction; CNT_WIDTH = clog2(MAX_SEGS)+1.
- BREAKPOINT, 1'b1, trace_break_o value that marks the last segment of a transaction.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  asynchronous active-high reset.
- txn_valid_i  in  1  transaction header valid.
- txn_ready_o  out  1  header accepted when valid&ready.
- txn_id_i  in  ID_WIDTH  transaction ID.
- seg_valid_i  in  1  segment valid.
- seg_ready_o  out  1  segment accepted when valid&ready.
- seg_sel_i  in  SEL_WIDTH  target queue of segment.
- seg_last_i  in  1  last segment of transaction.
- seg_abort_i  in  1  terminate current transaction.
- full_i  in  1  re-order control full (any internal queue).
- queue_full_i  in  NUM_QUEUES  per-queue full.
- queue_push_o  out  NUM_QUEUES  one-hot segment push to queue.
- trace_id_push_o  out  1  push ID entry.
- trace_id_value_o  out  ID_WIDTH  ID value.
- trace_push_o  out  1  push trace entry.
- trace_sel_o  out  SEL_WIDTH  trace queue selector.
- trace_break_o  out  1  trace breakpoint flag.
- trace_update_o  out  1  mark last pushed trace entry as breakpoint.
- busy_o  out  1  transaction open (state ACTIVE).

Behaviour:
- Clock/reset: one clock (clk_i); reset is asynchronous and active-high (arst_i).
- Reset state: IDLE, seg_cnt=0, id_q=0. All registered outputs are 0: queue_push_o, trace_id_push_o, trace_id_value_o, trace_push_o, trace_sel_o, trace_break_o, trace_update_o. busy_o=0.
- Reset asserted mid-transaction: open transaction is discarded; no update is emitted.
- FSM states are IDLE and ACTIVE.
- IDLE:
  - txn_ready_o=1 and seg_ready_o=0.
  - On txn accept: id_q<=txn_id_i, seg_cnt<=0, go to ACTIVE.
  - seg_abort_i is ignored.
- ACTIVE ready rule: txn_ready_o=0. seg_ready_o = ~full_i & ~queue_full_i[seg_sel_i], combinational.
- ACTIVE, segment accepted: next cycle, one-cycle pulses:
  - queue_push_o = one-hot(seg_sel_i).
  - trace_push_o=1 with trace_sel_o=seg_sel_i.
  - trace_break_o = BREAKPOINT if (seg_last_i | seg_abort_i | seg_cnt==MAX_SEGS-1), else ~BREAKPOINT.
  - trace_id_push_o=1 with trace_id_value_o=id_q, only on the segment where seg_cnt==0 (ID is pushed together with the first segment).
  - If break: go to IDLE. Else seg_cnt++.
- ACTIVE, seg_abort_i=1 and no segment accepted:
  - seg_cnt==0: go to IDLE with no outputs (transaction silently dropped, ID never pushed).
  - seg_cnt>0: trace_update_o pulses next cycle, go to IDLE.
  - Abort is honoured even while stalled by full_i.
- Latency: accept to trace/queue push is exactly 1 cycle. Back-to-back segments at 1 per cycle.
- Gap: at least one cycle separates the last trace push of one transaction from the first of the next, so a trace_update_o never coincides with a trace_push_o.
- MAX_SEGS reached: break is forced. Segments arriving before the next header stall (seg_ready_o=0 in IDLE).
- Upstream must hold seg/txn fields stable while valid and not ready. The bench checks this; the RTL does not.
- Widths: seg_cnt compares against MAX_SEGS-1 at CNT_WIDTH with no wrap. Selector values ≥ NUM_QUEUES are undefined usage; the RTL drives queue_push_o=0 but still pushes the trace entry.

Decomposition:
- Package reorder_logic_pkg holds shared constants/typedefs:
  - clog2 function.
  - ID_WIDTH, SEL_WIDTH, CNT_WIDTH derivations.
  - BREAKPOINT default.
  - FSM state encoding (IDLE=1'b0, ACTIVE=1'b1).
  - The same package is to be reused by the re-order control.
- No sub-module needed; the one-hot decode is a small inline function.

Test Plan:
- Basic transaction: id=5, segs sel=2,0,3 (last on 3rd), no stalls -> cycle+1 of first: trace_id_push_o=1/value 5. trace_push_o x3 with sel 2,0,3 and break 0,0,1. queue_push_o 0100,0001,1000. Back to IDLE.
- Stall: full_i=1 for 3 cycles mid-stream -> seg_ready_o=0 and no pushes during the stall; resumes with correct order, no duplicates.
- Per-queue stall: queue_full_i[1]=1, seg_sel_i=1 -> stalled; same cycle switch to sel=0 -> accepted, queue_push_o=0001.
- Abort after 2 segs (no seg valid) -> single trace_update_o pulse, no trace_push_o. Abort before any seg -> no outputs, no ID push. Abort with seg valid -> that entry has break=1, no update.
- MAX_SEGS=4 with seg_last_i never set -> 4th entry break=1. 5th segment stalls until a new header; new header id=9 -> ID push with next segment.
- arst_i pulse mid-transaction -> all outputs 0 asynchronously, state IDLE, txn_ready_o=1 after release.
